// File: rtl/temp_avg_pkg.sv
// Shared types and helpers for the multi-channel temperature averager.
package temp_avg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned WIN_LOG2_DEF = 6;
  localparam int unsigned ACC_W_DEF    = DATA_W_DEF + WIN_LOG2_DEF;

  // Accumulator width: WIN samples of DATA_W bits each can never overflow it.
  function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned win_log2);
    return data_w + win_log2;
  endfunction

  function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned data_w);
    return ch * data_w;
  endfunction

endpackage

// File: rtl/temp_avg_chan.sv
// One channel: window accumulator, averaging shift, optional min/max trackers.
// Min/max tracking is built only when TEMP_AVG_MINMAX_EN is defined.
module temp_avg_chan
  import temp_avg_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned WIN_LOG2 = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              tick_i,
  input  logic              first_i,
  input  logic              close_i,
  input  logic [DATA_W-1:0] sample_i,
  output logic [DATA_W-1:0] avg_o,
  output logic [DATA_W-1:0] min_o,
  output logic [DATA_W-1:0] max_o
);

  localparam int unsigned ACC_W = acc_width(DATA_W, WIN_LOG2);

  logic [ACC_W-1:0]  acc_q, acc_d, sum_s;
  logic [DATA_W-1:0] avg_q, avg_d;

  // The closing sample is folded in before the shift.
  assign sum_s = acc_q + ACC_W'(sample_i);

  // Accumulator and average next-state
  always_comb begin
    acc_d = acc_q;
    avg_d = avg_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (tick_i && close_i) begin
      acc_d = '0;
      avg_d = sum_s[ACC_W-1:WIN_LOG2];
    end else if (tick_i) begin
      acc_d = sum_s;
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator and average registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      avg_q <= '0;
    end else begin
      acc_q <= acc_d;
      avg_q <= avg_d;
    end
  end

  assign avg_o = avg_q;

`ifdef TEMP_AVG_MINMAX_EN
  logic [DATA_W-1:0] min_q, min_d, max_q, max_d;
  logic [DATA_W-1:0] min_out_q, min_out_d, max_out_q, max_out_d;
  logic [DATA_W-1:0] run_min_s, run_max_s;

  // First sample of a window seeds both trackers.
  assign run_min_s = (first_i || (sample_i < min_q)) ? sample_i : min_q;
  assign run_max_s = (first_i || (sample_i > max_q)) ? sample_i : max_q;

  // Tracker and latched min/max next-state
  always_comb begin
    min_d     = min_q;
    max_d     = max_q;
    min_out_d = min_out_q;
    max_out_d = max_out_q;
    if (clr_i) begin
      min_d = '0;
      max_d = '0;
    end else if (tick_i && close_i) begin
      min_d     = '0;
      max_d     = '0;
      min_out_d = run_min_s;
      max_out_d = run_max_s;
    end else if (tick_i) begin
      min_d = run_min_s;
      max_d = run_max_s;
    end else begin
      min_d = min_q;
      max_d = max_q;
    end
  end

  // Tracker and latched min/max registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_q     <= '0;
      max_q     <= '0;
      min_out_q <= '0;
      max_out_q <= '0;
    end else begin
      min_q     <= min_d;
      max_q     <= max_d;
      min_out_q <= min_out_d;
      max_out_q <= max_out_d;
    end
  end

  assign min_o = min_out_q;
  assign max_o = max_out_q;
`else
  logic unused_first_s;
  assign unused_first_s = first_i;
  assign min_o = '0;
  assign max_o = '0;
`endif

endmodule

// File: rtl/temp_avg_multi.sv
// Multi-channel windowed temperature averager: FSM, prescaler, sample counter.
// Optional per-channel min/max tracking under TEMP_AVG_MINMAX_EN.
module temp_avg_multi
  import temp_avg_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned N_CH     = 4,
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned WIN_LOG2 = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic [N_CH*DATA_W-1:0] sample_in,
  output logic [N_CH*DATA_W-1:0] avg_out,
  output logic                   avg_valid,
  output logic                   tick_p,
  output logic                   win_p,
  output logic [N_CH*DATA_W-1:0] min_out,
  output logic [N_CH*DATA_W-1:0] max_out
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_e              state_q;
  logic [PW-1:0]       presc_q;
  logic [WIN_LOG2-1:0] cnt_q;
  logic                tick_p_q, win_p_q, avg_valid_q;
  logic                close_s, first_s;

  assign close_s = tick_p_q && (cnt_q == {WIN_LOG2{1'b1}});
  assign first_s = (cnt_q == {WIN_LOG2{1'b0}});

  // Control FSM with prescaler, sample counter and pulse outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      cnt_q       <= '0;
      tick_p_q    <= 1'b0;
      win_p_q     <= 1'b0;
      avg_valid_q <= 1'b0;
    end else if (clr) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      cnt_q       <= '0;
      tick_p_q    <= 1'b0;
      win_p_q     <= 1'b0;
      avg_valid_q <= 1'b0;
    end else begin
      win_p_q     <= close_s;
      avg_valid_q <= close_s;
      tick_p_q    <= 1'b0;
      // A pending tick is consumed even on the edge that enters PAUSE.
      if (tick_p_q) begin
        cnt_q <= close_s ? {WIN_LOG2{1'b0}} : cnt_q + WIN_LOG2'(1);
      end else begin
        cnt_q <= cnt_q;
      end
      case (state_q)
        IDLE: begin
          presc_q <= '0;
          if (en) state_q <= RUN;
          else    state_q <= IDLE;
        end
        RUN: begin
          if (!en) begin
            state_q <= PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            presc_q  <= '0;
            tick_p_q <= 1'b1;
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        PAUSE: begin
          if (en) state_q <= RUN;
          else    state_q <= PAUSE;
        end
        default: begin
          state_q <= IDLE;
          presc_q <= '0;
        end
      endcase
    end
  end

  assign tick_p    = tick_p_q;
  assign win_p     = win_p_q;
  assign avg_valid = avg_valid_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    temp_avg_chan #(
      .DATA_W  (DATA_W),
      .WIN_LOG2(WIN_LOG2)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (clr),
      .tick_i  (tick_p_q),
      .first_i (first_s),
      .close_i (close_s),
      .sample_i(sample_in[ch_lsb(k, DATA_W) +: DATA_W]),
      .avg_o   (avg_out[ch_lsb(k, DATA_W) +: DATA_W]),
      .min_o   (min_out[ch_lsb(k, DATA_W) +: DATA_W]),
      .max_o   (max_out[ch_lsb(k, DATA_W) +: DATA_W])
    );
  end

endmodule

// File: tb/tb_temp_avg_multi.sv
// Directed self-checking bench for temp_avg_multi (TICK_DIV=4, WIN_LOG2=2, N_CH=2),
// plus a WIN_LOG2=10 instance for the full-scale accumulator check.
module tb_temp_avg_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] sample_in = '0;
  logic [15:0] avg_out, min_out, max_out;
  logic        avg_valid, tick_p, win_p;

  logic        en_b = 1'b0;
  logic        clr_b = 1'b0;
  logic [15:0] sample_b = {8'd255, 8'd255};
  logic [15:0] avg_b, min_b, max_b;
  logic        avg_valid_b, tick_p_b, win_p_b;

  int n_checks = 0;
  int n_errors = 0;
  int tick_cnt = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  temp_avg_multi #(.DATA_W(8), .N_CH(2), .TICK_DIV(4), .WIN_LOG2(2)) u_dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .sample_in(sample_in),
    .avg_out(avg_out), .avg_valid(avg_valid), .tick_p(tick_p), .win_p(win_p),
    .min_out(min_out), .max_out(max_out)
  );

  temp_avg_multi #(.DATA_W(8), .N_CH(2), .TICK_DIV(4), .WIN_LOG2(10)) u_dut_big (
    .clk(clk), .rst(rst), .en(en_b), .clr(clr_b), .sample_in(sample_b),
    .avg_out(avg_b), .avg_valid(avg_valid_b), .tick_p(tick_p_b), .win_p(win_p_b),
    .min_out(min_b), .max_out(max_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_s(input logic [7:0] c0, input logic [7:0] c1);
    sample_in = {c1, c0};
  endtask

  task automatic restart();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  // Returns in the cycle where tick_p is high; the next edge accumulates sample_in.
  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!tick_p && n < 20);
    if (!tick_p) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    cyc = 0;
    tick_cnt = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (tick_p) tick_cnt++;
    end while (!avg_valid && cyc < budget);
    if (!avg_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_minmax(input string tag, input logic [7:0] mn0, input logic [7:0] mx0,
                            input logic [7:0] mn1, input logic [7:0] mx1);
`ifdef TEMP_AVG_MINMAX_EN
    chk({tag, "_min"}, {16'd0, min_out}, {16'd0, mn1, mn0});
    chk({tag, "_max"}, {16'd0, max_out}, {16'd0, mx1, mx0});
`else
    chk({tag, "_min"}, {16'd0, min_out}, 32'd0 & {24'd0, mn0 & mn1 & mx0 & mx1});
    chk({tag, "_max"}, {16'd0, max_out}, 32'd0);
`endif
  endtask

  initial begin
    // Reset state
    set_s(8'd20, 8'd100);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_avg", {16'd0, avg_out}, 32'd0);
    chk("rst_valid", {31'd0, avg_valid}, 32'd0);
    chk("rst_tick", {31'd0, tick_p}, 32'd0);
    chk("rst_win", {31'd0, win_p}, 32'd0);
    chk_minmax("rst", 8'd0, 8'd0, 8'd0, 8'd0);
    chk("rst_avg_big", {16'd0, avg_b}, 32'd0);

    // Constant samples from reset release
    rst = 1'b1;
    en  = 1'b1;
    wait_valid(40);
    chk("const_lat", cyc, 32'd18);
    chk("const_ticks", tick_cnt, 32'd4);
    chk("const_win", {31'd0, win_p}, 32'd1);
    chk("const_avg", {16'd0, avg_out}, {16'd0, 8'd100, 8'd20});
    chk_minmax("const", 8'd20, 8'd20, 8'd100, 8'd100);
    wait_valid(40);
    chk("const_period", cyc, 32'd16);
    chk("const_ticks2", tick_cnt, 32'd4);
    @(posedge clk); #1;
    chk("valid_single", {31'd0, avg_valid}, 32'd0);
    chk("win_single", {31'd0, win_p}, 32'd0);

    // Ramp on ch0: 10+20+30+41 = 101, >>2 = 25
    restart();
    wait_tick(); set_s(8'd10, 8'd100);
    wait_tick(); set_s(8'd20, 8'd100);
    wait_tick(); set_s(8'd30, 8'd100);
    wait_tick(); set_s(8'd41, 8'd100);
    wait_valid(20);
    chk("ramp_avg", {16'd0, avg_out}, {16'd0, 8'd100, 8'd25});
    chk_minmax("ramp", 8'd10, 8'd41, 8'd100, 8'd100);

    // Pause after the 2nd tick: 8+16+24+33 = 81, >>2 = 20
    restart();
    wait_tick(); set_s(8'd8, 8'd200);
    wait_tick(); set_s(8'd16, 8'd200);
    en = 1'b0;
    tick_cnt = 0;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (tick_p) tick_cnt++;
      if (avg_valid) cyc++;
    end
    chk("pause_ticks", tick_cnt, 32'd0);
    chk("pause_valid", cyc, 32'd0);
    en = 1'b1;
    wait_tick(); set_s(8'd24, 8'd200);
    wait_tick(); set_s(8'd33, 8'd200);
    wait_valid(20);
    chk("pause_avg", {16'd0, avg_out}, {16'd0, 8'd200, 8'd20});
    chk_minmax("pause", 8'd8, 8'd33, 8'd200, 8'd200);

    // clr on the window-closing tick edge
    restart();
    set_s(8'd40, 8'd60);
    repeat (4) wait_tick();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_valid", {31'd0, avg_valid}, 32'd0);
    chk("clr_win", {31'd0, win_p}, 32'd0);
    chk("clr_avg_hold", {16'd0, avg_out}, {16'd0, 8'd200, 8'd20});
    wait_valid(40);
    chk("clr_fresh_lat", cyc, 32'd18);
    chk("clr_fresh_ticks", tick_cnt, 32'd4);
    chk("clr_avg", {16'd0, avg_out}, {16'd0, 8'd60, 8'd40});
    chk_minmax("clr", 8'd40, 8'd40, 8'd60, 8'd60);

    // Full-scale samples over a 1024-sample window
    en_b = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!avg_valid_b && cyc < 5000);
    chk("big_valid", {31'd0, avg_valid_b}, 32'd1);
    chk("big_lat", cyc, 32'd4098);
    chk("big_avg", {16'd0, avg_b}, {16'd0, 8'd255, 8'd255});
    en_b = 1'b0;

    // Asynchronous reset mid-window, between clock edges
    restart();
    set_s(8'd50, 8'd70);
    wait_tick();
    wait_tick();
    #3;
    rst = 1'b0;
    #1;
    chk("arst_avg", {16'd0, avg_out}, 32'd0);
    chk("arst_tick", {31'd0, tick_p}, 32'd0);
    chk_minmax("arst", 8'd0, 8'd0, 8'd0, 8'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    en  = 1'b0;
    tick_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (tick_p || avg_valid) tick_cnt++;
    end
    chk("arst_idle", tick_cnt, 32'd0);
    en = 1'b1;
    wait_valid(40);
    chk("arst_restart_lat", cyc, 32'd18);
    chk("arst_restart_avg", {16'd0, avg_out}, {16'd0, 8'd70, 8'd50});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/temp_avg_multi.md
Name: temp_avg_multi

Overview:
Parametrised multi-channel successor to the single-channel temperature averager. A programmable prescaler generates a sample tick. On each tick, every channel accumulates its sample. After 2^WIN_LOG2 ticks, each channel's window mean is latched with a one-cycle valid pulse. The block sits between the sensor sample bus and the display/logging path, and exposes tick and window pulses for status LEDs.

Parameters:
DATA_W, 8, sample and average width per channel (unsigned)
N_CH, 4, number of channels
TICK_DIV, 50000000, clock cycles per sample tick (>=2)
WIN_LOG2, 6, log2 of samples per window (1..10); window length WIN = 2^WIN_LOG2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
en  in  1  run enable; 0 pauses all counting
clr  in  1  synchronous restart of the current window
sample_in  in  N_CH*DATA_W  channel samples; ch k at bits [k*DATA_W +: DATA_W]
avg_out  out  N_CH*DATA_W  latched window averages, same packing
avg_valid  out  1  one-cycle pulse when avg_out updates
tick_p  out  1  one-cycle pulse per sample tick
win_p  out  1  one-cycle pulse on the window-closing tick
min_out  out  N_CH*DATA_W  per-channel window minimum (optional feature)
max_out  out  N_CH*DATA_W  per-channel window maximum (optional feature)

Behaviour:
- Reset (rst=0, asynchronous): all outputs, counters, accumulators and the state register go to 0; state is IDLE.
- FSM states:
  - IDLE: prescaler held at 0. Goes to RUN when en=1.
  - RUN: prescaler counts. Goes to PAUSE when en=0.
  - PAUSE: prescaler, sample count and accumulators hold. Goes to RUN when en=1.
  - clr=1 in any state forces IDLE on the next edge.
- Prescaler: counts 0..TICK_DIV-1 in RUN and wraps to 0. tick_p is registered: it is high for the one cycle after the edge where the count was TICK_DIV-1.
- Accumulation: on an edge with tick_p=1, each channel does acc += sample_in[k].
  - acc width is DATA_W+WIN_LOG2, so it can never overflow.
  - The sample counter increments from 0 to WIN-1.
- Window close: on a tick edge with sample count = WIN-1:
  - avg_out[k] <= (acc[k] + sample_in[k]) >> WIN_LOG2, truncating (the closing sample is included).
  - acc <= 0 and sample count <= 0.
  - avg_valid and win_p are high for exactly the following cycle.
- Latency: from the tick_p cycle of the last sample, avg_out and avg_valid appear 1 cycle later.
- avg_out holds between windows and is unaffected by en, clr or pause.
- clr: clears the prescaler, sample count, accumulators and min/max trackers. It does not clear avg_out, min_out or max_out.
  - clr coincident with a window-close tick: clr wins; no avg_valid or win_p, avg_out unchanged.
- en falling on the same edge as a tick: that tick still accumulates; counting freezes afterwards.
- tick_p, win_p and avg_valid are never high for two consecutive cycles.

Optional Feature:
TEMP_AVG_MINMAX_EN defined:
- Per-channel running min and max are tracked over the window.
- The trackers are seeded by the first sample of each window.
- min_out and max_out are latched on the same edge as avg_out.
TEMP_AVG_MINMAX_EN undefined:
- min_out and max_out remain as ports and are tied to 0; no tracker logic is synthesised.

Decomposition:
- Package temp_avg_pkg holds:
  - the state enum (IDLE, RUN, PAUSE);
  - the localparam for accumulator width (DATA_W+WIN_LOG2);
  - a channel-slice helper function.
- Sub-module temp_avg_chan: one channel's accumulator, the averaging shift, and the optional min/max trackers. It is generate-instantiated N_CH times. The top level holds the FSM, prescaler and sample counter.

Test Plan (TICK_DIV=4, WIN_LOG2=2, N_CH=2 unless noted):
- Constant ch0=20, ch1=100, en=1 from reset release -> avg_out={100,20}, with avg_valid and win_p pulsing once per 16 cycles, 1 cycle after the 4th tick_p.
- ch0 ramps 10,20,30,41 over one window -> avg_out ch0=25 (101>>2, truncated). With MINMAX_EN: min_out=10, max_out=41.
- Both channels at 255 for a window with WIN_LOG2=10 -> avg_out=255 each, no wrap, correct accumulator width.
- en=0 after the 2nd tick for 10 cycles, then en=1 -> no tick_p during the pause; window closes after 2 more ticks with the correct mean.
- clr asserted on the window-closing tick edge -> no avg_valid, avg_out keeps the previous value, and the next window requires 4 fresh ticks.
- rst pulled low mid-window between clock edges -> all outputs 0 immediately (asynchronous); after release the block is in IDLE and needs en to restart.
